// File: rtl/dcache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : dcache_fill_fsm
// Purpose  : Data-cache miss handler. It stalls the pipeline, streams word reads
//            for a whole block, writes each returned word into the data array,
//            and writes the tag array when the last word arrives.
// Revision : 1.0  initial release
// ============================================================================
module dcache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           fsm_busy,
    output logic                           mem_enable,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] data_word_index,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int c_idx_w = $clog2(BLOCK_WORDS);
    localparam int c_off_w = c_idx_w + 1;
    localparam logic [c_idx_w:0] c_words = (c_idx_w + 1)'(BLOCK_WORDS);
    localparam logic [c_idx_w:0] c_last  = (c_idx_w + 1)'(BLOCK_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                         r_state;
    logic [c_idx_w:0]               r_req_cnt;
    logic [c_idx_w:0]               r_ret_cnt;
    // Only the block-aligned upper bits of the fill base need storing.
    logic [ADDR_WIDTH-1:c_off_w]    r_fill_base_hi;

    logic w_filling;
    logic w_req_pending;
    logic w_last_word;

    assign w_filling     = (r_state == S_FILL);
    assign w_req_pending = w_filling && (r_req_cnt < c_words);
    assign w_last_word   = (r_ret_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_req_cnt      <= '0;
            r_ret_cnt      <= '0;
            r_fill_base_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_detected) begin
                        r_fill_base_hi <= miss_address[ADDR_WIDTH-1:c_off_w];
                        r_req_cnt      <= '0;
                        r_ret_cnt      <= '0;
                        r_state        <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_req_pending) begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                    if (memory_data_valid) begin
                        r_ret_cnt <= r_ret_cnt + 1'b1;
                        if (w_last_word) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        // Busy follows the miss combinationally so the stall lands in the miss cycle.
        fsm_busy         = w_filling || miss_detected;
        mem_enable       = w_req_pending;
        memory_address   = '0;
        if (w_req_pending) begin
            memory_address = {r_fill_base_hi, r_req_cnt[c_idx_w-1:0], 1'b0};
        end
        write_data_array = w_filling && memory_data_valid;
        write_tag_array  = w_filling && memory_data_valid && w_last_word;
        data_word_index  = r_ret_cnt[c_idx_w-1:0];
        fill_data        = memory_data;
    end

endmodule
`default_nettype wire
